// File: rtl/dram_port_master.sv
// Burst initiator for the synchronous byte DRAM port: turns read/write burst
// requests into one registered DRAM access per cycle.
module dram_port_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wvalid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rlast,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_t              state_r, state_s;
  logic [LEN_W-1:0]    len_r, cnt_r;
  logic [ADDR_W-1:0]   addr_r, address_r;
  logic [DATA_W-1:0]   data_r, rdata_r;
  logic                wren_r, done_r, rvalid_r, rlast_r;
  logic                req_ready_r, wready_r;
  logic                rd_v1_r, rd_last1_r;
  logic                accept_s, whs_s, last_beat_s;

  assign req_ready = req_ready_r;
  assign wready    = wready_r;
  assign rvalid    = rvalid_r;
  assign rdata     = rdata_r;
  assign rlast     = rlast_r;
  assign done      = done_r;
  assign address   = address_r;
  assign data      = data_r;
  assign wren      = wren_r;

  // Next-state decode; DRAIN exits on the done pulse of either burst type
  always_comb begin
    accept_s    = req_valid && (state_r == IDLE);
    whs_s       = wvalid && (state_r == WRITE);
    last_beat_s = (cnt_r == len_r);
    state_s     = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = req_write ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (whs_s && last_beat_s) begin
          state_s = DRAIN;
        end else begin
          state_s = WRITE;
        end
      end
      READ: begin
        if (last_beat_s) begin
          state_s = DRAIN;
        end else begin
          state_s = READ;
        end
      end
      DRAIN: begin
        if (done_r) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst datapath, DRAM-side outputs and the two-stage read return pipeline
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_r       <= '0;
      cnt_r       <= '0;
      addr_r      <= '0;
      address_r   <= '0;
      data_r      <= '0;
      rdata_r     <= '0;
      wren_r      <= 1'b0;
      done_r      <= 1'b0;
      rvalid_r    <= 1'b0;
      rlast_r     <= 1'b0;
      rd_v1_r     <= 1'b0;
      rd_last1_r  <= 1'b0;
      req_ready_r <= 1'b1;
      wready_r    <= 1'b0;
    end else begin
      req_ready_r <= (state_s == IDLE);
      wready_r    <= (state_s == WRITE);
      wren_r      <= 1'b0;
      if (accept_s) begin
        len_r  <= req_len;
        addr_r <= req_addr;
        cnt_r  <= '0;
        if (!req_write) begin
          address_r <= req_addr;
        end
      end else if (state_r == READ) begin
        cnt_r <= cnt_r + LEN_ONE;
        if (!last_beat_s) begin
          address_r <= address_r + ADDR_ONE;
        end
      end else if (whs_s) begin
        wren_r    <= 1'b1;
        address_r <= addr_r;
        data_r    <= wdata;
        addr_r    <= addr_r + ADDR_ONE;
        cnt_r     <= cnt_r + LEN_ONE;
      end
      // stage 1 marks the cycle q carries an issued read; stage 2 is rvalid
      rd_v1_r    <= (state_r == READ);
      rd_last1_r <= (state_r == READ) && last_beat_s;
      rvalid_r   <= rd_v1_r;
      rlast_r    <= rd_v1_r && rd_last1_r;
      done_r     <= (whs_s && last_beat_s) || (rd_v1_r && rd_last1_r);
      if (rd_v1_r) begin
        rdata_r <= q;
      end
    end
  end

endmodule

// File: tb/tb_dram_port_master.sv
// Randomized scoreboard bench for dram_port_master with a behavioural DRAM
// and a flat reference memory predicting every DRAM write and read beat.
module tb_dram_port_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [2:0]  req_len = 3'd0;
  logic        wvalid = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  q;
  logic        req_ready, wready, rvalid, rlast, done, wren;
  logic [7:0]  rdata, data;
  logic [15:0] address;

  always #5 clock = ~clock;

  dram_port_master #(.ADDR_W(16), .DATA_W(8), .LEN_W(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .done(done),
    .address(address), .data(data), .wren(wren), .q(q)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Behavioural DRAM: unwritten locations read back init_val
  logic [7:0] mem     [0:65535];
  bit         written [0:65535];
  always @(posedge clock) begin
    if (wren) begin
      mem[address]     <= data;
      written[address] <= 1'b1;
    end else begin
      q <= written[address] ? mem[address] : init_val(address);
    end
  end

  logic [7:0] ref_mem [0:65535];

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [7:0]  d;
    bit          last;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  exp_t iq[$];
  int   dq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   gap [8];
  logic [7:0] wd [8];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, read beat or done
  always @(negedge clock) begin
    if (reset_n) begin
      if (iq.size() > 0 && iq[0].cyc <= cyc) begin
        check("issue_cycle", cyc, iq[0].cyc);
        check("issue_addr", address, iq[0].a);
        check("issue_wren", wren, 0);
        void'(iq.pop_front());
      end
      if (wren) begin
        if (wq.size() == 0) check("wren_unexpected", wren, 0);
        else begin
          check("wr_cycle", cyc, wq[0].cyc);
          check("wr_addr", address, wq[0].a);
          check("wr_data", data, wq[0].d);
          void'(wq.pop_front());
        end
      end else if (wq.size() > 0 && wq[0].cyc < cyc) begin
        check("wren_missing", wren, 1);
        void'(wq.pop_front());
      end
      if (rvalid) begin
        if (rq.size() == 0) check("rvalid_unexpected", rvalid, 0);
        else begin
          check("rd_cycle", cyc, rq[0].cyc);
          check("rd_data", rdata, rq[0].d);
          check("rd_last", rlast, rq[0].last);
          void'(rq.pop_front());
        end
      end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
        check("rvalid_missing", rvalid, 1);
        void'(rq.pop_front());
      end
      if (rlast && !rvalid) check("rlast_without_rvalid", rlast, 0);
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", done, 0);
        else check("done_cycle", cyc, dq.pop_front());
      end else if (dq.size() > 0 && dq[0] < cyc) begin
        check("done_missing", done, 1);
        void'(dq.pop_front());
      end
    end
  end

  task automatic issue_req(input bit wr, input logic [15:0] a, input logic [2:0] l, output int acc);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
    while (!req_ready && n < 20) begin @(posedge clock); #1; n++; end
    check("req_ready_wait", req_ready, 1);
    acc = cyc;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 16'($urandom); req_len = 3'($urandom);
  endtask

  task automatic wait_idle(input int exp_cyc, input bit junk);
    int n = 0;
    while (!req_ready && n < 40) begin
      if (junk) begin wvalid = 1'($urandom); wdata = 8'($urandom); end
      @(posedge clock); #1; n++;
    end
    wvalid = 1'b0;
    check("req_ready_cycle", cyc, exp_cyc);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [2:0] l);
    int acc;
    logic [15:0] aj;
    issue_req(1'b0, a, l, acc);
    for (int j = 0; j <= int'(l); j++) begin
      aj = a + 16'(j);
      iq.push_back('{cyc: acc + 1 + j, a: aj, d: 8'h00, last: 1'b0});
      rq.push_back('{cyc: acc + 3 + j, a: aj, d: ref_mem[aj], last: (j == int'(l))});
    end
    dq.push_back(acc + 3 + int'(l));
    wait_idle(acc + 4 + int'(l), 1'b1);
  endtask

  // Delivers nbeats beats; a full burst is nbeats = len+1
  task automatic do_write(input logic [15:0] a, input logic [2:0] l, input int nbeats);
    int acc, n, k;
    logic [15:0] aj;
    k = 0;
    issue_req(1'b1, a, l, acc);
    for (int j = 0; j < nbeats; j++) begin
      aj = a + 16'(j);
      repeat (gap[j]) begin wvalid = 1'b0; @(posedge clock); #1; end
      wvalid = 1'b1; wdata = wd[j]; n = 0;
      while (!wready && n < 20) begin @(posedge clock); #1; n++; end
      check("wready_wait", wready, 1);
      k = cyc;
      wq.push_back('{cyc: k + 1, a: aj, d: wd[j], last: (j == int'(l))});
      ref_mem[aj] = wd[j];
      if (j == int'(l)) dq.push_back(k + 1);
      @(posedge clock); #1;
      wvalid = 1'b0;
    end
    if (nbeats > int'(l)) begin
      check("wready_after_last", wready, 0);
      wait_idle(k + 2, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rlast"}, rlast, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_address"}, address, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_wren"}, wren, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    for (int i = 0; i < 8; i++) gap[i] = 0;

    // Reset state, then idle after release
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("post_reset");

    // Single write then read-after-write
    wd[0] = 8'hA5;
    do_write(16'h0003, 3'd0, 1);
    do_read(16'h0003, 3'd0);

    // Preload 0..7 = 0x10..0x17 through the port, then an 8-beat read
    for (int i = 0; i < 8; i++) wd[i] = 8'h10 + 8'(i);
    do_write(16'h0000, 3'd7, 8);
    do_read(16'h0000, 3'd7);

    // Write burst with a two-cycle wvalid gap between beats 1 and 2
    for (int i = 0; i < 4; i++) wd[i] = 8'h01 + 8'(i);
    gap[2] = 2;
    do_write(16'h0004, 3'd3, 4);
    gap[2] = 0;
    do_read(16'h0004, 3'd3);

    // Address wrap
    do_read(16'hFFFE, 3'd3);

    // Reset mid-burst: two beats commit, the third is cut off by reset
    wd[0] = 8'hC1; wd[1] = 8'hC2;
    do_write(16'h0100, 3'd3, 2);
    wvalid = 1'b1; wdata = 8'hEE;
    @(posedge clock); #1;
    check("abort_wren_before", wren, 1);
    reset_n = 1'b0;
    #1;
    wvalid = 1'b0;
    check("abort_wren", wren, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_done", done, 0);
    check("abort_wready", wready, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    wq.delete(); rq.delete(); iq.delete(); dq.delete();
    @(posedge clock); #1;
    do_read(16'h0100, 3'd3);
    wd[0] = 8'h77; wd[1] = 8'h88;
    do_write(16'h0102, 3'd1, 2);
    do_read(16'h0100, 3'd3);

    // Randomized mix of bursts near 0 and near the top of the address space
    for (int t = 0; t < 60; t++) begin
      logic [2:0] l;
      a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31)) : 16'hFFF0 + 16'($urandom_range(0, 15));
      l = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) begin
          wd[i] = 8'($urandom);
          gap[i] = $urandom_range(0, 2);
        end
        do_write(a, l, int'(l) + 1);
      end else begin
        do_read(a, l);
      end
    end
    for (int i = 0; i < 8; i++) gap[i] = 0;

    repeat (6) @(posedge clock);
    #1;
    check("queues_empty", 32'(wq.size() + rq.size() + iq.size() + dq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dram_port_master.md
Name: dram_port_master

Overview:
- Initiator side of the team's synchronous byte DRAM port: address/data/wren out, q in.
  - The DRAM registers `q` on the clock edge whenever wren=0.
  - It writes on the clock edge whenever wren=1.
- Converts processor-side burst requests into per-cycle DRAM accesses:
  - reads: 1–8 beats, returned as a valid-qualified stream;
  - writes: 1–8 beats, consumed through a valid/ready handshake.
- Sits between the processor load/store unit and DRAM. All DRAM-side outputs are registered.

Parameters:
- ADDR_W, 16, DRAM address width; burst addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, DRAM data width.
- LEN_W, 3, burst length field width; beats = req_len+1 (1..2^LEN_W).

Ports:
- clock, input, 1: single clock; all state changes on posedge.
- reset_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: high only in IDLE; a request is accepted in a cycle with req_valid&&req_ready.
- req_write, input, 1: 1 = write burst, 0 = read burst.
- req_addr, input, ADDR_W: start address.
- req_len, input, LEN_W: beats minus one.
- wvalid, input, 1: write beat present.
- wdata, input, DATA_W: write beat data.
- wready, output, 1: high only in WRITE state.
- rvalid, output, 1: read beat valid (no backpressure).
- rdata, output, DATA_W: read beat data.
- rlast, output, 1: final read beat.
- done, output, 1: one-cycle pulse at burst completion.
- address, output, ADDR_W: to DRAM.
- data, output, DATA_W: to DRAM write data.
- wren, output, 1: to DRAM, 1 = write.
- q, input, DATA_W: from DRAM, valid the cycle after the address is presented with wren=0.

Behaviour:
- Reset values:
  - FSM = IDLE, so req_ready=1.
  - wready=0, rvalid=0, rlast=0, done=0.
  - rdata=0, address=0, data=0, wren=0.
  - Beat counter=0, read pipeline valids cleared.
- Reset is asynchronous at any time, including mid-burst:
  - The burst is aborted and wren drops immediately.
  - A write presented in the same cycle as reset assertion is not guaranteed to commit.
  - No further rvalid is issued for the aborted burst.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - On acceptance in cycle 0, capture req_len and req_addr.
  - Go to WRITE if req_write=1, else READ.
  - If req_write=0, also register address=req_addr, wren=0 for cycle 1.
- READ:
  - Issues one address per cycle in cycles 1..len+1, with address incrementing by 1 each cycle.
  - Increments wrap from 2^ADDR_W-1 to 0.
  - wren=0 throughout.
  - After the last issue, go to DRAIN.
- Read return timing:
  - A 2-stage valid pipeline tracks issued addresses.
  - q is sampled at the end of cycle i+2 into rdata.
  - rvalid=1 for beat i in cycle 3+i; beats are contiguous.
  - rlast=1 and done=1 in cycle 3+len.
  - DRAIN returns to IDLE so that req_ready=1 in cycle 4+len.
- WRITE:
  - wready=1 in this state.
  - For each cycle k with wvalid&&wready, register wren=1, address=current address, data=wdata for cycle k+1, then increment the address (with wrap).
  - Cycles with wvalid=0 produce wren=0 in the next cycle, with address and data held. A stray DRAM read in such a cycle is harmless.
- Last write beat (handshake in cycle k):
  - wready=0 from cycle k+1.
  - wren=1 and done=1 in cycle k+1; the DRAM commits at the end of k+1.
  - req_ready=1 in cycle k+2.
  - wren returns to 0 in cycle k+2.
- wvalid outside WRITE is ignored.
- req_* inputs are ignored outside IDLE.
- rdata holds its last value when rvalid=0.
- done is never asserted outside the cases above.
- A read accepted immediately after a write done observes the written data (read-after-write is ordered).

Test Plan:
- Reset check: hold reset_n=0 → all outputs at the reset values above, with req_ready=1. Release reset → outputs unchanged until a request.
- Single write then read:
  - Write addr 0x0003, len 0, data 0xA5, wvalid held high → wren=1 with address=0x0003, data=0xA5 exactly one cycle, done in that same cycle.
  - Then read addr 0x0003, len 0 → rvalid/rlast/done in cycle 3 with rdata=0xA5.
- Burst read:
  - Preload DRAM 0..7 = 0x10..0x17; read addr 0, len 7, accepted in cycle 0 → rvalid in cycles 3..10 with rdata 0x10..0x17 in order.
  - rlast and done only in cycle 10; req_ready=0 in cycles 1..10, then 1 in cycle 11.
- Write burst with gaps:
  - len 3 at addr 4, data 0x01..0x04, with wvalid low for 2 cycles between beats 1 and 2 → exactly 4 wren=1 cycles at addresses 4..7.
  - wren=0 during the gaps; readback returns 0x01..0x04.
- Address wrap: read addr 0xFFFE, len 3 → issued addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-burst:
  - Assert reset_n=0 after 2 of 4 write beats → wren=0 immediately, req_ready=1, no done.
  - Only the first 2 addresses are modified.
  - The next request completes normally.
